pci_arbiter: RTL and testbench

PCI_ARBITER -- requirements
Module: pci_arbiter

---
 rtl/pci_arbiter.sv | 143 ++++++++++++++
 tb/tb_pci_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pci_arbiter.sv
// rtl/pci_arbiter.sv - four-master PCI round-robin arbiter with grant timeout
// Optional bus parking is selected with the PCI_ARB_PARK_EN macro.
module pci_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int NREQ    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  input  logic            frame,
  input  logic            irdy,
  output logic [1:0]      owner,
  output logic            bus_idle,
  output logic            timeout_err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_GNT  = 3'd1;
  localparam logic [2:0] ST_BUSY = 3'd2;
  localparam logic [2:0] ST_TURN = 3'd3;
`ifdef PCI_ARB_PARK_EN
  localparam logic [2:0] ST_PARK = 3'd4;
`endif

  localparam int              CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE      = NREQ'(1);

  logic [2:0]      state;
  logic [CW-1:0]   wait_cnt;
  logic [1:0]      winner;
  logic            any_req;
  logic            other_req;
  logic            found;
  logic [1:0]      idx;
  logic [NREQ-1:0] own_mask;

  // Round-robin search begins just after the current owner and wraps back to it.
  always_comb begin
    winner  = owner;
    found   = 1'b0;
    idx     = '0;
    any_req = (req != '1);
    for (int k = 1; k <= NREQ; k++) begin
      idx = owner + k[1:0];
      if (!found && !req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign own_mask  = ONE << owner;
  assign other_req = ((req | own_mask) != '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      gnt         <= '1;
      owner       <= 2'd3;
      bus_idle    <= 1'b1;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      bus_idle    <= frame & irdy;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            gnt      <= ~(ONE << winner);
            owner    <= winner;
            wait_cnt <= '0;
            state    <= ST_GNT;
          end
        end
        ST_GNT: begin
          if (!frame) begin
            state <= ST_BUSY;
          end else if (req[owner]) begin
            gnt   <= '1;
            state <= ST_TURN;
          end else if (wait_cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            gnt         <= '1;
            state       <= ST_TURN;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_BUSY: begin
          // Preemption only drops the grant; the owner keeps the bus until it idles.
          if (other_req) begin
            gnt <= '1;
          end
          if (bus_idle) begin
            if (other_req || gnt[owner] || req[owner]) begin
              gnt   <= '1;
              state <= ST_TURN;
            end else begin
              wait_cnt <= '0;
              state    <= ST_GNT;
            end
          end
        end
        ST_TURN: begin
          // The single all-high TURN clock is the dead cycle, so arbitrate on its exit.
          if (any_req) begin
            gnt      <= ~(ONE << winner);
            owner    <= winner;
            wait_cnt <= '0;
            state    <= ST_GNT;
          end else begin
`ifdef PCI_ARB_PARK_EN
            gnt   <= ~own_mask;
            state <= ST_PARK;
`else
            state <= ST_IDLE;
`endif
          end
        end
`ifdef PCI_ARB_PARK_EN
        ST_PARK: begin
          if (any_req) begin
            if (winner == owner) begin
              wait_cnt <= '0;
              state    <= ST_GNT;
            end else begin
              gnt   <= '1;
              state <= ST_TURN;
            end
          end
        end
`endif
        default: begin
          gnt   <= '1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_arbiter.sv
// tb/tb_pci_arbiter.sv - directed scoreboard bench for pci_arbiter
module tb_pci_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b1111;
  logic       frame = 1'b1;
  logic       irdy = 1'b1;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       bus_idle;
  logic       timeout_err;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       bus_idle;
    logic       terr;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    n_assert = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  pci_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .gnt(gnt),
    .frame(frame),
    .irdy(irdy),
    .owner(owner),
    .bus_idle(bus_idle),
    .timeout_err(timeout_err)
  );

  function automatic logic [3:0] gn(input int m);
    logic [3:0] v;
    v = 4'b1111;
    v[m] = 1'b0;
    return v;
  endfunction

  task automatic push(input logic [3:0] eg, input logic [1:0] eo, input logic eb,
                      input logic et, input string tag);
    exp_t e;
    e.gnt = eg;
    e.owner = eo;
    e.bus_idle = eb;
    e.terr = et;
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    e = sb.pop_front();
    t = tags.pop_front();
    n_assert++;
    assert (gnt === e.gnt) else begin
      n_fail++;
      $error("FAIL %s gnt: got %b want %b", t, gnt, e.gnt);
    end
    n_assert++;
    assert (owner === e.owner) else begin
      n_fail++;
      $error("FAIL %s owner: got %0d want %0d", t, owner, e.owner);
    end
    n_assert++;
    assert (bus_idle === e.bus_idle) else begin
      n_fail++;
      $error("FAIL %s bus_idle: got %b want %b", t, bus_idle, e.bus_idle);
    end
    n_assert++;
    assert (timeout_err === e.terr) else begin
      n_fail++;
      $error("FAIL %s timeout_err: got %b want %b", t, timeout_err, e.terr);
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic f, input logic i,
                     input logic [3:0] eg, input logic [1:0] eo, input logic et,
                     input string tag);
    @(negedge clk);
    req = r;
    frame = f;
    irdy = i;
    push(eg, eo, f & i, et, tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    int order[5];
    int m;
    order = '{0, 1, 2, 3, 0};

    #12;
    push(4'b1111, 2'd3, 1'b1, 1'b0, "reset");
    check_out();
    @(negedge clk);
    rst = 1'b1;

    // First grant, drop without frame, then hand-over to master 2
    cyc(4'b1010, 1, 1, gn(0), 2'd0, 0, "first_grant");
    cyc(4'b1011, 1, 1, 4'b1111, 2'd0, 0, "drop_turn");
    cyc(4'b1011, 1, 1, gn(2), 2'd2, 0, "grant2");

    // Master 2 never starts a transaction
    for (int k = 1; k <= 15; k++) cyc(4'b1011, 1, 1, gn(2), 2'd2, 0, "hold_gnt");
    cyc(4'b1011, 1, 1, 4'b1111, 2'd2, 1, "timeout");
    cyc(4'b1011, 1, 1, gn(2), 2'd2, 0, "terr_one_clk");

    // Master 2 transaction, then everyone goes quiet
    cyc(4'b1011, 0, 1, gn(2), 2'd2, 0, "busy2");
    cyc(4'b1011, 0, 0, gn(2), 2'd2, 0, "data2");
    cyc(4'b1011, 1, 0, gn(2), 2'd2, 0, "last2");
    cyc(4'b1111, 1, 1, gn(2), 2'd2, 0, "rel2");
    cyc(4'b1111, 1, 1, 4'b1111, 2'd2, 0, "turn2");
`ifdef PCI_ARB_PARK_EN
    for (int k = 0; k < 4; k++) cyc(4'b1111, 1, 1, gn(2), 2'd2, 0, "park2");
    cyc(4'b1101, 1, 1, 4'b1111, 2'd2, 0, "park_leave");
`else
    for (int k = 0; k < 4; k++) cyc(4'b1111, 1, 1, 4'b1111, 2'd2, 0, "idle_nopark");
`endif

    // Master 1 busy, master 3 preempts
    cyc(4'b1101, 1, 1, gn(1), 2'd1, 0, "grant1");
    cyc(4'b1101, 0, 1, gn(1), 2'd1, 0, "busy1");
    cyc(4'b0101, 0, 0, 4'b1111, 2'd1, 0, "preempt");
    cyc(4'b0101, 0, 0, 4'b1111, 2'd1, 0, "preempt_hold");
    cyc(4'b0111, 1, 1, 4'b1111, 2'd1, 0, "busy_end");
    cyc(4'b0111, 1, 1, 4'b1111, 2'd1, 0, "turn1");
    cyc(4'b0111, 1, 1, gn(3), 2'd3, 0, "grant3");

    // All four requesting: order 0,1,2,3,0
    m = 3;
    foreach (order[j]) begin
      cyc(4'b0000, 0, 0, gn(m), 2'(m), 0, "rr_busy");
      cyc(4'b0000, 1, 1, 4'b1111, 2'(m), 0, "rr_preempt");
      cyc(4'b0000, 1, 1, 4'b1111, 2'(m), 0, "rr_turn");
      cyc(4'b0000, 1, 1, gn(order[j]), 2'(order[j]), 0, "rr_grant");
      m = order[j];
    end

    // Asynchronous reset in the middle of a transaction
    cyc(4'b0000, 0, 0, gn(0), 2'd0, 0, "busy0");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    push(4'b1111, 2'd3, 1'b1, 1'b0, "async_rst");
    check_out();
    @(posedge clk);
    #1;
    push(4'b1111, 2'd3, 1'b1, 1'b0, "rst_hold");
    check_out();
    @(negedge clk);
    req = 4'b1111;
    frame = 1'b1;
    irdy = 1'b1;
    rst = 1'b1;
    cyc(4'b0000, 1, 1, gn(0), 2'd0, 0, "prio0_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
